execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  EX stage of the 5-stage RV64 core: between decode and mem_access. Computes ALU / compare / M-ext results and
//  registers the complete EX/MEM bundle that mem_access consumes. Single-cycle ops take one cycle. MUL/MULHU/DIV/DIVU/REM/REMU
//  run on a 64-iteration shift-add / restoring-divide engine that stalls decode. A branch taken in MEM (flush_i) squashes EX.
// PARAMETERS
//  XLEN     64  datapath width; fixed, other values unsupported
//  ITER     64  multi-cycle iterations (= XLEN)
// PORTS
//  CLK             in   1   clock, posedge
//  RESET           in   1   asynchronous, active-low reset
//  EN              in   1   valid instruction presented from decode
//  flush_i         in   1   take_branch from mem_access; squash current EX work
//  alu_op          in   5   0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10-15 BEQ/BNE/BLT/BGE/BLTU/BGEU,
//                           16 MUL,17 MULHU,18 DIV,19 DIVU,20 REM,21 REMU; 22-31 -> result 0
//  rs1_val,rs2_val in   64  operands
//  imm             in   64  sign-extended immediate
//  use_imm         in   1   operand B = imm instead of rs2_val
//  is_load,is_store in  1   memory instruction (mutually exclusive)
//  mem_para_i      in   3   funct3 size/sign code, passed through
//  rd_i            in   5   destination register
//  write_back_i    in   1   instruction writes rd
//  branch_i        in   1   conditional branch
//  PC_i            in   64  instruction PC
//  EN_o            out  1   mem op valid -> mem_access.EN
//  LOAD_o          out  1   1 load, 0 store
//  address         out  64  rs1_val + imm (wrap mod 2^64)
//  value           out  64  store data = rs2_val
//  mem_para_o      out  3   registered mem_para_i
//  alu_res         out  64  result; branches: 64'd1 taken, 64'd0 not taken
//  rd_o            out  5   destination; 0 on bubble
//  write_back_o    out  1   0 on bubble
//  branch_flag_o   out  1   registered branch_i; 0 on bubble
//  branch_offset_o out  64  registered imm
//  PC_o            out  64  registered PC_i
//  stall_o         out  1   high while state != IDLE; decode holds its inputs
// BEHAVIOUR
//  - Reset, async: every output = 0; state=IDLE; iteration counter=0. RESET mid-BUSY abandons the op with no output.
//  - Output bundle is registered; it updates only on accept, DONE, or bubble.
//  - Accept = IDLE & EN & !flush_i.
//  - Single-cycle op accepted at edge N: bundle valid after edge N. Shifts use opB[5:0]. SRA is arithmetic.
//    SLT and BLT/BGE compare signed; SLTU and BLTU/BGEU compare unsigned.
//  - Idle cycle with !EN or flush_i: bubble. EN_o, write_back_o, branch_flag_o and rd_o = 0; other fields don't-care.
//  - FSM IDLE -> BUSY on accept of alu_op 16-21. Operands are latched; cnt=0; the output register gets a bubble.
//    BUSY: one iteration per cycle, cnt++. After the iteration with cnt==63, go to DONE.
//    DONE: load the bundle with the result, write_back_o = write_back_i, then return to IDLE.
//    stall_o is high for exactly 65 cycles: 64 BUSY + 1 DONE.
//  - MUL returns the low 64 bits of the 128-bit product; MULHU returns the high 64 bits (unsigned).
//  - DIV/REM: divide |a| by |b|. Negate the quotient if sign(a)^sign(b); the remainder takes sign(a).
//  - DIV/REM special cases, applied in DONE:
//    b==0: DIV/DIVU return all-ones; REM/REMU return a.
//    DIV of -2^63 by -1 returns -2^63; REM of -2^63 by -1 returns 0.
//  - flush_i in BUSY or DONE: go to IDLE the next cycle, drive a bubble, drop the result. flush_i in IDLE blocks accept.
//  - flush_i takes priority over EN and over DONE.
// TESTING
//  1 ADD rs1=5, imm=-7, use_imm -> next cycle alu_res=FFFF_FFFF_FFFF_FFFE, write_back_o=1, stall_o=0.
//  2 BLTU rs1=1, rs2=FFFF..FF, branch_i -> alu_res=1, branch_flag_o=1, branch_offset_o=imm, PC_o=PC_i.
//  3 DIV -7/2 -> stall_o high 65 cycles; then alu_res=-3. REM of the same operands returns -1. Next decode op is accepted the cycle after DONE.
//  4 DIVU 9/0 -> all-ones; REM -2^63/-1 -> 0; MULHU FFFF..FF*2 -> 1.
//  5 flush_i at BUSY cycle 10 of a MUL -> IDLE next cycle, bubble, no write_back_o pulse for that rd.
//  6 SD: is_store, rs1=0x1000, imm=8, rs2=0xAB -> EN_o=1, LOAD_o=0, address=0x1008, value=0xAB. RESET low mid-DIV -> all outputs 0, stall_o 0.

Source files
------------

// File: rtl/execute_stage.sv
// execute_stage
//   EX stage of the 5-stage RV64 pipeline, sitting between decode and mem_access.
//   Single-cycle ALU, compare and branch ops complete in the cycle they are accepted.
//   MUL/MULHU/DIV/DIVU/REM/REMU use a shared 64-iteration shift-add / restoring-divide
//   engine. The engine stalls decode until the result is loaded into the EX/MEM bundle.
//   A taken branch in MEM (flush_i) squashes whatever EX is doing.
//
// Ports
//   CLK, RESET            clock (posedge), asynchronous active-low reset
//   EN, flush_i           instruction valid from decode, squash from mem_access
//   alu_op                operation select (0-15 ALU/branch, 16-21 M-ext, others -> 0)
//   rs1_val, rs2_val, imm operands and sign-extended immediate; use_imm picks imm as operand B
//   is_load, is_store     memory instruction flags
//   mem_para_i, rd_i, write_back_i, branch_i, PC_i   sideband carried to MEM
//   EN_o, LOAD_o, address, value, mem_para_o         memory request to mem_access
//   alu_res, rd_o, write_back_o                      result and writeback control
//   branch_flag_o, branch_offset_o, PC_o             branch info for MEM
//   stall_o               high while the M-ext engine owns the stage
//
// State table
//   state  | meaning
//   S_IDLE | accepting instructions from decode
//   S_BUSY | one multiply/divide iteration per cycle, r_cnt = iteration index
//   S_DONE | final fix-up; result is written into the output bundle

module execute_stage (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        EN,
    input  logic        flush_i,
    input  logic [4:0]  alu_op,
    input  logic [63:0] rs1_val,
    input  logic [63:0] rs2_val,
    input  logic [63:0] imm,
    input  logic        use_imm,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  mem_para_i,
    input  logic [4:0]  rd_i,
    input  logic        write_back_i,
    input  logic        branch_i,
    input  logic [63:0] PC_i,
    output logic        EN_o,
    output logic        LOAD_o,
    output logic [63:0] address,
    output logic [63:0] value,
    output logic [2:0]  mem_para_o,
    output logic [63:0] alu_res,
    output logic [4:0]  rd_o,
    output logic        write_back_o,
    output logic        branch_flag_o,
    output logic [63:0] branch_offset_o,
    output logic [63:0] PC_o,
    output logic        stall_o
);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_SLL   = 5'd2;
    localparam logic [4:0] OP_SLT   = 5'd3;
    localparam logic [4:0] OP_SLTU  = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_OR    = 5'd8;
    localparam logic [4:0] OP_AND   = 5'd9;
    localparam logic [4:0] OP_BEQ   = 5'd10;
    localparam logic [4:0] OP_BNE   = 5'd11;
    localparam logic [4:0] OP_BLT   = 5'd12;
    localparam logic [4:0] OP_BGE   = 5'd13;
    localparam logic [4:0] OP_BLTU  = 5'd14;
    localparam logic [4:0] OP_BGEU  = 5'd15;
    localparam logic [4:0] OP_MUL   = 5'd16;
    localparam logic [4:0] OP_MULHU = 5'd17;
    localparam logic [4:0] OP_DIV   = 5'd18;
    localparam logic [4:0] OP_DIVU  = 5'd19;
    localparam logic [4:0] OP_REM   = 5'd20;
    localparam logic [4:0] OP_REMU  = 5'd21;

    localparam logic [63:0] MIN_NEG  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_cnt;

    // Latched multi-cycle instruction
    logic [4:0]  r_op;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [4:0]  r_rd;
    logic        r_wb;
    logic        r_br;
    logic [63:0] r_imm;
    logic [63:0] r_pc;

    // Engine: {r_hi, r_lo} is the product (mul) or {remainder, dividend/quotient} (div)
    logic [63:0] r_hi;
    logic [63:0] r_lo;
    logic [63:0] r_mcand;

    logic [63:0] w_opb;
    logic        w_accept;
    logic        w_is_mop;
    logic        w_start;
    logic        w_lt_s;
    logic        w_lt_u;
    logic        w_eq;
    logic [63:0] w_alu;

    logic        w_signed_div;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [63:0] w_abs_a;
    logic [63:0] w_abs_b;

    logic        w_eng_mul;
    logic [64:0] w_sum;
    logic [64:0] w_shift;
    logic        w_ge;
    logic [63:0] w_diff;
    logic [63:0] w_hi_next;
    logic [63:0] w_lo_next;

    logic        w_b_zero;
    logic        w_ovf;
    logic        w_neg_q;
    logic [63:0] w_mres;

    assign w_opb    = use_imm ? imm : rs2_val;
    assign w_accept = (r_state == S_IDLE) && EN && !flush_i;
    assign w_is_mop = (alu_op >= OP_MUL) && (alu_op <= OP_REMU);
    assign w_start  = w_accept && w_is_mop;
    assign stall_o  = (r_state != S_IDLE);

    // ---------------- single-cycle ALU ----------------
    assign w_lt_s = $signed(rs1_val) < $signed(w_opb);
    assign w_lt_u = rs1_val < w_opb;
    assign w_eq   = rs1_val == w_opb;

    always_comb begin
        w_alu = 64'd0;
        case (alu_op)
            OP_ADD:  w_alu = rs1_val + w_opb;
            OP_SUB:  w_alu = rs1_val - w_opb;
            OP_SLL:  w_alu = rs1_val << w_opb[5:0];
            OP_SLT:  w_alu = {63'd0, w_lt_s};
            OP_SLTU: w_alu = {63'd0, w_lt_u};
            OP_XOR:  w_alu = rs1_val ^ w_opb;
            OP_SRL:  w_alu = rs1_val >> w_opb[5:0];
            OP_SRA:  w_alu = $signed(rs1_val) >>> w_opb[5:0];
            OP_OR:   w_alu = rs1_val | w_opb;
            OP_AND:  w_alu = rs1_val & w_opb;
            OP_BEQ:  w_alu = {63'd0, w_eq};
            OP_BNE:  w_alu = {63'd0, !w_eq};
            OP_BLT:  w_alu = {63'd0, w_lt_s};
            OP_BGE:  w_alu = {63'd0, !w_lt_s};
            OP_BLTU: w_alu = {63'd0, w_lt_u};
            OP_BGEU: w_alu = {63'd0, !w_lt_u};
            default: w_alu = 64'd0;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == 6'd63) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- iterative engine ----------------
    // Signed divide works on magnitudes; signs are reapplied in S_DONE.
    assign w_signed_div = (alu_op == OP_DIV) || (alu_op == OP_REM);
    assign w_a_neg      = w_signed_div && rs1_val[63];
    assign w_b_neg      = w_signed_div && w_opb[63];
    assign w_abs_a      = w_a_neg ? (64'd0 - rs1_val) : rs1_val;
    assign w_abs_b      = w_b_neg ? (64'd0 - w_opb) : w_opb;

    assign w_eng_mul = (r_op == OP_MUL) || (r_op == OP_MULHU);

    // Multiply step: add multiplicand when multiplier LSB is set, shift the 129-bit pair right.
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : 65'd0);

    // Divide step: shift next dividend bit into the partial remainder, subtract if it fits.
    // When it fits the difference is below the divisor, so 64 bits hold it exactly.
    assign w_shift = {r_hi, r_lo[63]};
    assign w_ge    = w_shift >= {1'b0, r_mcand};
    assign w_diff  = w_shift[63:0] - r_mcand;

    always_comb begin
        w_hi_next = r_hi;
        w_lo_next = r_lo;
        if (w_eng_mul) begin
            w_hi_next = w_sum[64:1];
            w_lo_next = {w_sum[0], r_lo[63:1]};
        end else begin
            w_hi_next = w_ge ? w_diff : w_shift[63:0];
            w_lo_next = {r_lo[62:0], w_ge};
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_cnt   <= 6'd0;
            r_op    <= 5'd0;
            r_a     <= 64'd0;
            r_b     <= 64'd0;
            r_rd    <= 5'd0;
            r_wb    <= 1'b0;
            r_br    <= 1'b0;
            r_imm   <= 64'd0;
            r_pc    <= 64'd0;
            r_hi    <= 64'd0;
            r_lo    <= 64'd0;
            r_mcand <= 64'd0;
        end else if (w_start) begin
            r_cnt <= 6'd0;
            r_op  <= alu_op;
            r_a   <= rs1_val;
            r_b   <= w_opb;
            r_rd  <= rd_i;
            r_wb  <= write_back_i;
            r_br  <= branch_i;
            r_imm <= imm;
            r_pc  <= PC_i;
            r_hi  <= 64'd0;
            if ((alu_op == OP_MUL) || (alu_op == OP_MULHU)) begin
                r_lo    <= w_opb;
                r_mcand <= rs1_val;
            end else begin
                r_lo    <= w_abs_a;
                r_mcand <= w_abs_b;
            end
        end else if ((r_state == S_BUSY) && !flush_i) begin
            r_cnt <= r_cnt + 6'd1;
            r_hi  <= w_hi_next;
            r_lo  <= w_lo_next;
        end
    end

    // ---------------- final result fix-up ----------------
    assign w_b_zero = (r_b == 64'd0);
    assign w_ovf    = (r_a == MIN_NEG) && (r_b == ALL_ONES);
    assign w_neg_q  = r_a[63] ^ r_b[63];

    always_comb begin
        w_mres = 64'd0;
        case (r_op)
            OP_MUL:   w_mres = r_lo;
            OP_MULHU: w_mres = r_hi;
            OP_DIV: begin
                if (w_b_zero)     w_mres = ALL_ONES;
                else if (w_ovf)   w_mres = MIN_NEG;
                else if (w_neg_q) w_mres = 64'd0 - r_lo;
                else              w_mres = r_lo;
            end
            OP_DIVU:  w_mres = w_b_zero ? ALL_ONES : r_lo;
            OP_REM: begin
                if (w_b_zero)     w_mres = r_a;
                else if (w_ovf)   w_mres = 64'd0;
                else if (r_a[63]) w_mres = 64'd0 - r_hi;
                else              w_mres = r_hi;
            end
            OP_REMU:  w_mres = w_b_zero ? r_a : r_hi;
            default:  w_mres = 64'd0;
        endcase
    end

    // ---------------- EX/MEM bundle ----------------
    // In IDLE every non-accepted cycle (and an M-op accept) is a bubble.
    // In BUSY the bundle holds; flush beats DONE.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            EN_o            <= 1'b0;
            LOAD_o          <= 1'b0;
            address         <= 64'd0;
            value           <= 64'd0;
            mem_para_o      <= 3'd0;
            alu_res         <= 64'd0;
            rd_o            <= 5'd0;
            write_back_o    <= 1'b0;
            branch_flag_o   <= 1'b0;
            branch_offset_o <= 64'd0;
            PC_o            <= 64'd0;
        end else if (r_state == S_IDLE) begin
            if (w_accept && !w_is_mop) begin
                EN_o            <= is_load || is_store;
                LOAD_o          <= is_load;
                address         <= rs1_val + imm;
                value           <= rs2_val;
                mem_para_o      <= mem_para_i;
                alu_res         <= w_alu;
                rd_o            <= rd_i;
                write_back_o    <= write_back_i;
                branch_flag_o   <= branch_i;
                branch_offset_o <= imm;
                PC_o            <= PC_i;
            end else begin
                EN_o          <= 1'b0;
                rd_o          <= 5'd0;
                write_back_o  <= 1'b0;
                branch_flag_o <= 1'b0;
            end
        end else if (flush_i) begin
            EN_o          <= 1'b0;
            rd_o          <= 5'd0;
            write_back_o  <= 1'b0;
            branch_flag_o <= 1'b0;
        end else if (r_state == S_DONE) begin
            EN_o            <= 1'b0;
            LOAD_o          <= 1'b0;
            mem_para_o      <= 3'd0;
            alu_res         <= w_mres;
            rd_o            <= r_rd;
            write_back_o    <= r_wb;
            branch_flag_o   <= r_br;
            branch_offset_o <= r_imm;
            PC_o            <= r_pc;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

    logic        CLK;
    logic        RESET;
    logic        EN;
    logic        flush_i;
    logic [4:0]  alu_op;
    logic [63:0] rs1_val;
    logic [63:0] rs2_val;
    logic [63:0] imm;
    logic        use_imm;
    logic        is_load;
    logic        is_store;
    logic [2:0]  mem_para_i;
    logic [4:0]  rd_i;
    logic        write_back_i;
    logic        branch_i;
    logic [63:0] PC_i;
    logic        EN_o;
    logic        LOAD_o;
    logic [63:0] address;
    logic [63:0] value;
    logic [2:0]  mem_para_o;
    logic [63:0] alu_res;
    logic [4:0]  rd_o;
    logic        write_back_o;
    logic        branch_flag_o;
    logic [63:0] branch_offset_o;
    logic [63:0] PC_o;
    logic        stall_o;

    execute_stage dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .flush_i(flush_i), .alu_op(alu_op),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .use_imm(use_imm),
        .is_load(is_load), .is_store(is_store), .mem_para_i(mem_para_i), .rd_i(rd_i),
        .write_back_i(write_back_i), .branch_i(branch_i), .PC_i(PC_i),
        .EN_o(EN_o), .LOAD_o(LOAD_o), .address(address), .value(value),
        .mem_para_o(mem_para_o), .alu_res(alu_res), .rd_o(rd_o),
        .write_back_o(write_back_o), .branch_flag_o(branch_flag_o),
        .branch_offset_o(branch_offset_o), .PC_o(PC_o), .stall_o(stall_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] im;
        logic        ui;
        logic        ld;
        logic        st;
        logic        br;
        logic        wb;
        logic [63:0] res;
    } vec_t;

    // kind: 0 full single-cycle bundle, 1 M-ext result, 2 bubble
    typedef struct packed {
        logic [1:0]  kind;
        logic [63:0] res;
        logic        en_o;
        logic        load_o;
        logic [63:0] addr;
        logic [63:0] value;
        logic [2:0]  mp;
        logic [4:0]  rd;
        logic        wb;
        logic        br;
        logic [63:0] off;
        logic [63:0] pc;
    } exp_t;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[20];

    function automatic vec_t mkv(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] im, input logic ui, input logic ld,
                                 input logic st, input logic br, input logic wb,
                                 input logic [63:0] res);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.im = im; v.ui = ui;
        v.ld = ld; v.st = st; v.br = br; v.wb = wb; v.res = res;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic pop_cmp(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, ".EN_o"}, 64'(EN_o), 64'(e.en_o));
            chk({nm, ".write_back_o"}, 64'(write_back_o), 64'(e.wb));
            chk({nm, ".branch_flag_o"}, 64'(branch_flag_o), 64'(e.br));
            chk({nm, ".rd_o"}, 64'(rd_o), 64'(e.rd));
            if (e.kind != 2'd2) begin
                chk({nm, ".alu_res"}, alu_res, e.res);
                chk({nm, ".PC_o"}, PC_o, e.pc);
                chk({nm, ".branch_offset_o"}, branch_offset_o, e.off);
            end
            if (e.kind == 2'd0) begin
                chk({nm, ".LOAD_o"}, 64'(LOAD_o), 64'(e.load_o));
                chk({nm, ".address"}, address, e.addr);
                chk({nm, ".value"}, value, e.value);
                chk({nm, ".mem_para_o"}, 64'(mem_para_o), 64'(e.mp));
            end
        end
    endtask

    // Starts and ends on a negedge; the bundle is checked one posedge later.
    task automatic drive_vec(input string nm, input vec_t v, input logic [4:0] rd,
                             input logic [63:0] pc, input logic [2:0] mp,
                             input logic en, input logic fl);
        exp_t e;
        alu_op = v.op; rs1_val = v.a; rs2_val = v.b; imm = v.im; use_imm = v.ui;
        is_load = v.ld; is_store = v.st; branch_i = v.br; write_back_i = v.wb;
        rd_i = rd; PC_i = pc; mem_para_i = mp; EN = en; flush_i = fl;
        e = '0;
        if (en && !fl) begin
            e.kind = 2'd0; e.res = v.res; e.en_o = v.ld | v.st; e.load_o = v.ld;
            e.addr = v.a + v.im; e.value = v.b; e.mp = mp; e.rd = rd;
            e.wb = v.wb; e.br = v.br; e.off = v.im; e.pc = pc;
        end else begin
            e.kind = 2'd2;
        end
        sb.push_back(e);
        @(negedge CLK);
        pop_cmp(nm);
        chk({nm, ".stall_o"}, 64'(stall_o), 64'd0);
    endtask

    task automatic run_mop(input string nm, input logic [4:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] rd, input logic [63:0] res);
        exp_t e;
        int   n;
        alu_op = op; rs1_val = a; rs2_val = b; imm = 64'd0; use_imm = 1'b0;
        is_load = 1'b0; is_store = 1'b0; branch_i = 1'b0; write_back_i = 1'b1;
        rd_i = rd; PC_i = 64'h9000 + 64'(rd); mem_para_i = 3'd0; EN = 1'b1; flush_i = 1'b0;
        e = '0;
        e.kind = 2'd1; e.res = res; e.rd = rd; e.wb = 1'b1; e.pc = 64'h9000 + 64'(rd);
        sb.push_back(e);
        @(negedge CLK);
        chk({nm, ".accept_bubble_wb"}, 64'(write_back_o), 64'd0);
        n = 0;
        while (stall_o && n < 200) begin
            n++;
            @(negedge CLK);
        end
        chk({nm, ".stall_cycles"}, 64'(n), 64'd65);
        pop_cmp(nm);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int   wb_pulses;
        int   stall_seen;
        vec_t v;

        vecs[0]  = mkv(5'd0,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 1, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
        vecs[1]  = mkv(5'd14, 64'd1, ONES, 64'h40, 0, 0, 0, 1, 0, 64'd1);
        vecs[2]  = mkv(5'd1,  64'd3, 64'd5, 64'd0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
        vecs[3]  = mkv(5'd2,  64'd1, 64'h7F, 64'd0, 0, 0, 0, 0, 1, MINN);
        vecs[4]  = mkv(5'd3,  ONES, 64'd1, 64'd0, 0, 0, 0, 0, 1, 64'd1);
        vecs[5]  = mkv(5'd4,  ONES, 64'd1, 64'd0, 0, 0, 0, 0, 1, 64'd0);
        vecs[6]  = mkv(5'd5,  64'hF0F0, 64'hFF00, 64'd0, 0, 0, 0, 0, 1, 64'h0FF0);
        vecs[7]  = mkv(5'd6,  MINN, 64'd4, 64'd0, 0, 0, 0, 0, 1, 64'h0800_0000_0000_0000);
        vecs[8]  = mkv(5'd7,  MINN, 64'd4, 64'd0, 0, 0, 0, 0, 1, 64'hF800_0000_0000_0000);
        vecs[9]  = mkv(5'd8,  64'hF0F0, 64'hFF00, 64'd0, 0, 0, 0, 0, 1, 64'hFFF0);
        vecs[10] = mkv(5'd9,  64'hF0F0, 64'hFF00, 64'd0, 0, 0, 0, 0, 1, 64'hF000);
        vecs[11] = mkv(5'd10, 64'd7, 64'd7, 64'h20, 0, 0, 0, 1, 0, 64'd1);
        vecs[12] = mkv(5'd11, 64'd7, 64'd7, 64'h24, 0, 0, 0, 1, 0, 64'd0);
        vecs[13] = mkv(5'd12, ONES, 64'd1, 64'h28, 0, 0, 0, 1, 0, 64'd1);
        vecs[14] = mkv(5'd13, ONES, 64'd1, 64'h2C, 0, 0, 0, 1, 0, 64'd0);
        vecs[15] = mkv(5'd15, ONES, 64'd1, 64'h30, 0, 0, 0, 1, 0, 64'd1);
        vecs[16] = mkv(5'd25, 64'd5, 64'd5, 64'd0, 0, 0, 0, 0, 1, 64'd0);
        vecs[17] = mkv(5'd0,  64'h1000, 64'hAB, 64'd8, 1, 0, 1, 0, 0, 64'h1008);
        vecs[18] = mkv(5'd0,  64'h2000, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 1, 1, 0, 0, 1, 64'h1FF0);
        vecs[19] = mkv(5'd7,  64'hFFFF_FFFF_FFFF_FF00, 64'd0, 64'h44, 1, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF0);

        RESET = 1'b0; EN = 1'b0; flush_i = 1'b0; alu_op = 5'd0; rs1_val = 64'd0;
        rs2_val = 64'd0; imm = 64'd0; use_imm = 1'b0; is_load = 1'b0; is_store = 1'b0;
        mem_para_i = 3'd0; rd_i = 5'd0; write_back_i = 1'b0; branch_i = 1'b0; PC_i = 64'd0;
        repeat (2) @(negedge CLK);
        chk("reset.alu_res", alu_res, 64'd0);
        chk("reset.PC_o", PC_o, 64'd0);
        chk("reset.address", address, 64'd0);
        chk("reset.flags", {58'd0, EN_o, LOAD_o, write_back_o, branch_flag_o, stall_o, 1'b0}, 64'd0);
        RESET = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 20; i++) begin
            drive_vec($sformatf("vec%0d", i), vecs[i], 5'(i + 1), 64'h8000_0000 + 64'(4 * i),
                      3'(i), 1'b1, 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            v = mkv(5'd0, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0);
            case (i % 3)
                0: begin v.op = 5'd0; v.res = v.a + v.b; end
                1: begin v.op = 5'd1; v.res = v.a - v.b; end
                default: begin v.op = 5'd5; v.res = v.a ^ v.b; end
            endcase
            drive_vec($sformatf("rnd%0d", i), v, 5'(i + 3), 64'h4000 + 64'(i), 3'd1, 1'b1, 1'b0);
        end

        run_mop("div_m7_2", 5'd18, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD);
        drive_vec("after_done_add", vecs[0], 5'd7, 64'h7000, 3'd0, 1'b1, 1'b0);
        run_mop("rem_m7_2", 5'd20, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5, ONES);
        run_mop("divu_9_0", 5'd19, 64'd9, 64'd0, 5'd6, ONES);
        run_mop("rem_min_m1", 5'd20, MINN, ONES, 5'd8, 64'd0);
        run_mop("div_min_m1", 5'd18, MINN, ONES, 5'd9, MINN);
        run_mop("mulhu_ones_2", 5'd17, ONES, 64'd2, 5'd10, 64'd1);
        run_mop("mul_3_m5", 5'd16, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd11, 64'hFFFF_FFFF_FFFF_FFF1);
        run_mop("mul_big", 5'd16, 64'h1_0000_0001, 64'h1_0000_0001, 5'd12, 64'h2_0000_0001);
        run_mop("divu_100_7", 5'd19, 64'd100, 64'd7, 5'd13, 64'd14);
        run_mop("remu_100_7", 5'd21, 64'd100, 64'd7, 5'd14, 64'd2);
        run_mop("remu_5_0", 5'd21, 64'd5, 64'd0, 5'd15, 64'd5);
        run_mop("div_7_0", 5'd18, 64'd7, 64'd0, 5'd16, ONES);
        run_mop("rem_7_m2", 5'd20, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd17, 64'd1);
        run_mop("div_7_m2", 5'd18, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd18, 64'hFFFF_FFFF_FFFF_FFFD);

        // Flush at BUSY iteration 10 of a MUL: result must never be written back.
        drive_vec("pre_flush_add", vecs[2], 5'd20, 64'h5000, 3'd0, 1'b1, 1'b0);
        alu_op = 5'd16; rs1_val = 64'd3; rs2_val = 64'd5; use_imm = 1'b0; rd_i = 5'd21;
        write_back_i = 1'b1; branch_i = 1'b0; is_load = 1'b0; is_store = 1'b0; EN = 1'b1;
        @(negedge CLK);
        repeat (10) @(negedge CLK);
        flush_i = 1'b1;
        @(negedge CLK);
        chk("flush_busy.stall_o", 64'(stall_o), 64'd0);
        chk("flush_busy.write_back_o", 64'(write_back_o), 64'd0);
        chk("flush_busy.rd_o", 64'(rd_o), 64'd0);
        flush_i = 1'b0; EN = 1'b0;
        wb_pulses = 0;
        stall_seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge CLK);
            if (write_back_o) wb_pulses++;
            if (stall_o) stall_seen++;
        end
        chk("flush_busy.wb_pulses", 64'(wb_pulses), 64'd0);
        chk("flush_busy.stall_after", 64'(stall_seen), 64'd0);

        // Flush landing on the DONE cycle wins over loading the result.
        alu_op = 5'd16; rs1_val = 64'd6; rs2_val = 64'd7; rd_i = 5'd22; write_back_i = 1'b1; EN = 1'b1;
        @(negedge CLK);
        repeat (64) @(negedge CLK);
        chk("flush_done.in_done_stall", 64'(stall_o), 64'd1);
        flush_i = 1'b1;
        @(negedge CLK);
        chk("flush_done.write_back_o", 64'(write_back_o), 64'd0);
        chk("flush_done.rd_o", 64'(rd_o), 64'd0);
        chk("flush_done.stall_o", 64'(stall_o), 64'd0);
        flush_i = 1'b0;

        // Flush in IDLE and !EN produce bubbles after a writing instruction.
        drive_vec("wb_add1", vecs[0], 5'd23, 64'h6000, 3'd2, 1'b1, 1'b0);
        drive_vec("idle_flush", vecs[0], 5'd24, 64'h6004, 3'd2, 1'b1, 1'b1);
        drive_vec("wb_add2", vecs[18], 5'd25, 64'h6008, 3'd3, 1'b1, 1'b0);
        drive_vec("no_en", vecs[18], 5'd26, 64'h600C, 3'd3, 1'b0, 1'b0);

        // Reset in the middle of a DIV abandons it.
        drive_vec("pre_reset_ld", vecs[18], 5'd27, 64'h6010, 3'd4, 1'b1, 1'b0);
        alu_op = 5'd18; rs1_val = 64'd100; rs2_val = 64'd3; use_imm = 1'b0; is_load = 1'b0;
        rd_i = 5'd28; write_back_i = 1'b1; EN = 1'b1;
        @(negedge CLK);
        repeat (20) @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("mid_reset.alu_res", alu_res, 64'd0);
        chk("mid_reset.address", address, 64'd0);
        chk("mid_reset.PC_o", PC_o, 64'd0);
        chk("mid_reset.flags", {58'd0, EN_o, LOAD_o, write_back_o, branch_flag_o, stall_o, 1'b0}, 64'd0);
        EN = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        wb_pulses = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge CLK);
            if (write_back_o || stall_o) wb_pulses++;
        end
        chk("mid_reset.no_result", 64'(wb_pulses), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
